// File: rtl/memory_stage_unit_pkg.sv
// Shared types and constants for the memory stage.
// Optional feature macro: MEM_TIMEOUT_EN (ack watchdog, see mem_beat_ctrl).
package mem_stage_pkg;

    typedef enum logic [0:0] {
        MS_IDLE = 1'b0,
        MS_BUSY = 1'b1
    } ms_state_t;

    localparam int BEATS_VEC  = 4;
    localparam int BEAT_BYTES = 4;
    localparam int BEAT_CNT_W = 2;

    // Byte offset of a beat from the aligned base address.
    function automatic logic [31:0] beat_offset(input logic [BEAT_CNT_W-1:0] b);
        return 32'(b) * 32'(BEAT_BYTES);
    endfunction

endpackage

// File: rtl/memory_stage_unit_if.sv
// Data-memory req/ack bus between the memory stage (master) and memory (slave).
interface memory_stage_unit_if #(
    parameter int ADDR_W = 32,
    parameter int BUS_W  = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [BUS_W-1:0]  mem_wdata;
    logic [BUS_W-1:0]  mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/memory_stage_unit_beat_ctrl.sv
// Access sequencer: IDLE/BUSY FSM, beat counter, beat address generation,
// stall generation and (with MEM_TIMEOUT_EN) the ack watchdog.
module mem_beat_ctrl
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_op,
    input  logic                  vec,
    input  logic                  ack,
    input  logic [ADDR_W-1:0]     base_addr,
    output logic                  busy,
    output logic [BEAT_CNT_W-1:0] beat,
    output logic                  last_beat,
    output logic                  beat_done,
    output logic                  abort,
    output logic                  stall,
    output logic [ADDR_W-1:0]     addr
`ifdef MEM_TIMEOUT_EN
    ,
    output logic                  err
`endif
);

    if (TIMEOUT_CYC < 1) begin : g_timeout_range
        $error("TIMEOUT_CYC must be at least 1");
    end

    ms_state_t             state_q, state_d;
    logic [BEAT_CNT_W-1:0] beat_q, beat_d;
    logic [ADDR_W-1:0]     base_aligned;
    logic                  finish;

    assign busy         = (state_q == MS_BUSY);
    assign beat         = beat_q;
    assign last_beat    = vec ? (beat_q == BEAT_CNT_W'(BEATS_VEC - 1)) : 1'b1;
    assign beat_done    = busy && ack;
    assign finish       = (beat_done && last_beat) || abort;
    assign base_aligned = {base_addr[ADDR_W-1:2], 2'b00};
    // Address wraps naturally at 2^ADDR_W.
    assign addr         = busy ? (base_aligned + ADDR_W'(beat_offset(beat_q))) : '0;

`ifdef MEM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;

    // Watchdog: counts consecutive ack-less BUSY cycles, aborts on the last allowed one.
    always_comb begin
        abort  = busy && !ack && (wait_q == WAIT_W'(TIMEOUT_CYC - 1));
        wait_d = '0;
        if (busy && !ack && !abort) begin
            wait_d = wait_q + 1'b1;
        end
        err_d  = err_q | abort;
    end

    // Watchdog registers; the error flag is sticky until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign abort = 1'b0;
`endif

    // State and beat registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MS_IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Next state: start on any memory op, return to IDLE on final ack or abort.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MS_IDLE: if (mem_op) state_d = MS_BUSY;
            MS_BUSY: if (finish) state_d = MS_IDLE;
            default: state_d = MS_IDLE;
        endcase
    end

    // Beat counter update and stall; stall releases combinationally on the final ack.
    always_comb begin
        beat_d = beat_q;
        stall  = 1'b0;
        case (state_q)
            MS_IDLE: begin
                beat_d = '0;
                stall  = mem_op;
            end
            MS_BUSY: begin
                stall = !finish;
                if (finish) begin
                    beat_d = '0;
                end else if (beat_done) begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: begin
                beat_d = '0;
                stall  = 1'b0;
            end
        endcase
        if (!rst) begin
            stall = 1'b0;
        end
    end

endmodule

// File: rtl/memory_stage_unit.sv
// Memory pipeline stage: scalar/vector loads and stores over a 32-bit req/ack
// bus, lane select/assembly, and the stage-3 result registers.
// Optional feature macro: MEM_TIMEOUT_EN adds the mem_err port and ack watchdog.
module memory_stage_unit
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int VEC_W       = 128,
    parameter int BUS_W       = 32,
    parameter int REG_W       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                MemRead2,
    input  logic                MemWrite2,
    input  logic                RegWrite2,
    input  logic                VF2,
    input  logic [REG_W-1:0]    R_V_dest2,
    input  logic [ADDR_W-1:0]   ALURES,
    input  logic [VEC_W-1:0]    ALURES1,
    input  logic [VEC_W-1:0]    R3_V3_2,
    memory_stage_unit_if.master mem,
    output logic                stall,
    output logic                VF3,
    output logic                RegWrite3,
    output logic [REG_W-1:0]    R_V_dest3,
    output logic [VEC_W-1:0]    ResRV
`ifdef MEM_TIMEOUT_EN
    ,
    output logic                mem_err
`endif
);

    if (VEC_W != BEATS_VEC * BUS_W) begin : g_width_check
        $error("VEC_W must equal BEATS_VEC * BUS_W");
    end

    logic                  mem_op, store;
    logic                  busy, last_beat, beat_done, abort, final_ack;
    logic [BEAT_CNT_W-1:0] beat;
    logic [ADDR_W-1:0]     addr;

    logic [BUS_W-1:0]      wlane [BEATS_VEC];
    logic [VEC_W-1:0]      assembled;

    logic [VEC_W-1:0]      buf_q, buf_d;
    logic [VEC_W-1:0]      res_q, res_d;
    logic                  vf_q, vf_d;
    logic                  rw_q, rw_d;
    logic [REG_W-1:0]      dest_q, dest_d;

    // A store wins when both request bits are set.
    assign mem_op    = MemRead2 | MemWrite2;
    assign store     = MemWrite2;
    assign final_ack = beat_done && last_beat;

    mem_beat_ctrl #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .mem_op    (mem_op),
        .vec       (VF2),
        .ack       (mem.mem_ack),
        .base_addr (ALURES),
        .busy      (busy),
        .beat      (beat),
        .last_beat (last_beat),
        .beat_done (beat_done),
        .abort     (abort),
        .stall     (stall),
        .addr      (addr)
`ifdef MEM_TIMEOUT_EN
        ,
        .err       (mem_err)
`endif
    );

    // Per-lane write data slices and load assembly: the lane being acked takes rdata.
    for (genvar gi = 0; gi < BEATS_VEC; gi++) begin : g_lane
        assign wlane[gi] = R3_V3_2[gi*BUS_W +: BUS_W];
        assign assembled[gi*BUS_W +: BUS_W] =
            (beat == BEAT_CNT_W'(gi)) ? mem.mem_rdata : buf_q[gi*BUS_W +: BUS_W];
    end

    assign mem.mem_req   = busy;
    assign mem.mem_we    = busy & store;
    assign mem.mem_addr  = addr;
    assign mem.mem_wdata = busy ? wlane[beat] : '0;

    // Load buffer: cleared when an access starts so scalar loads zero-extend.
    always_comb begin
        buf_d = buf_q;
        if (!busy && mem_op) begin
            buf_d = '0;
        end else if (beat_done && !store) begin
            buf_d = assembled;
        end
    end

    // Stage-3 results: pass-through for ALU ops, load/store result on the final
    // ack, bubble otherwise (ResRV holds).
    always_comb begin
        res_d  = res_q;
        vf_d   = 1'b0;
        rw_d   = 1'b0;
        dest_d = '0;
        if (!busy && !mem_op) begin
            res_d  = ALURES1;
            vf_d   = VF2;
            rw_d   = RegWrite2;
            dest_d = R_V_dest2;
        end else if (final_ack) begin
            res_d  = store ? ALURES1 : assembled;
            vf_d   = VF2;
            rw_d   = RegWrite2 & ~store;
            dest_d = R_V_dest2;
        end
    end

    // Output and buffer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q  <= '0;
            res_q  <= '0;
            vf_q   <= 1'b0;
            rw_q   <= 1'b0;
            dest_q <= '0;
        end else begin
            buf_q  <= buf_d;
            res_q  <= res_d;
            vf_q   <= vf_d;
            rw_q   <= rw_d;
            dest_q <= dest_d;
        end
    end

    assign ResRV     = res_q;
    assign VF3       = vf_q;
    assign RegWrite3 = rw_q;
    assign R_V_dest3 = dest_q;

endmodule

// File: tb/tb_memory_stage_unit.sv
// Self-checking bench for memory_stage_unit: directed cases plus random
// ALU/load/store traffic against a transaction-level reference model.
module tb_memory_stage_unit;

    logic         clk = 1'b0;
    logic         rst;
    logic         MemRead2, MemWrite2, RegWrite2, VF2;
    logic [3:0]   R_V_dest2;
    logic [31:0]  ALURES;
    logic [127:0] ALURES1, R3_V3_2;
    logic         stall, VF3, RegWrite3;
    logic [3:0]   R_V_dest3;
    logic [127:0] ResRV;
`ifdef MEM_TIMEOUT_EN
    logic         mem_err;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    memory_stage_unit_if #(.ADDR_W(32), .BUS_W(32)) mem_if ();

    memory_stage_unit #(
        .ADDR_W(32), .VEC_W(128), .BUS_W(32), .REG_W(4), .TIMEOUT_CYC(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MemRead2  (MemRead2),
        .MemWrite2 (MemWrite2),
        .RegWrite2 (RegWrite2),
        .VF2       (VF2),
        .R_V_dest2 (R_V_dest2),
        .ALURES    (ALURES),
        .ALURES1   (ALURES1),
        .R3_V3_2   (R3_V3_2),
        .mem       (mem_if),
        .stall     (stall),
        .VF3       (VF3),
        .RegWrite3 (RegWrite3),
        .R_V_dest3 (R_V_dest3),
        .ResRV     (ResRV)
`ifdef MEM_TIMEOUT_EN
        ,
        .mem_err   (mem_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One instruction from the upstream stage; called just after a rising edge.
    task automatic run_op(input string nm, input bit mr, input bit mw, input bit rw, input bit vf,
                          input logic [3:0] dest, input logic [31:0] alures,
                          input logic [127:0] res1, input logic [127:0] sd,
                          input logic [127:0] rd, input int waits[4], input bit idle_ack);
        logic [127:0] exp_res;
        logic [31:0]  a, wl, rl;
        int           nb;
        MemRead2 = mr; MemWrite2 = mw; RegWrite2 = rw; VF2 = vf;
        R_V_dest2 = dest; ALURES = alures; ALURES1 = res1; R3_V3_2 = sd;
        mem_if.mem_ack   = idle_ack && !(mr || mw);
        mem_if.mem_rdata = $urandom;
        @(negedge clk);
        if (!(mr || mw)) begin
            check_val({nm, ".alu_stall"}, stall, 0);
            check_val({nm, ".alu_req"}, mem_if.mem_req, 0);
            @(posedge clk); #1;
            mem_if.mem_ack = 1'b0;
            exp_res = res1;
            check_val({nm, ".res"}, ResRV, exp_res);
            check_val({nm, ".rw3"}, RegWrite3, rw);
        end else begin
            check_val({nm, ".start_stall"}, stall, 1);
            check_val({nm, ".start_req"}, mem_if.mem_req, 0);
            @(posedge clk); #1;
            nb = vf ? 4 : 1;
            exp_res = '0;
            for (int b = 0; b < nb; b++) begin
                a  = (alures & 32'hFFFF_FFFC) + 32'(b * 4);
                wl = sd[32*b +: 32];
                rl = rd[32*b +: 32];
                for (int w = 0; w < waits[b]; w++) begin
                    mem_if.mem_ack = 1'b0;
                    @(negedge clk);
                    check_val({nm, ".wait_req"}, mem_if.mem_req, 1);
                    check_val({nm, ".wait_stall"}, stall, 1);
                    check_val({nm, ".wait_addr"}, mem_if.mem_addr, a);
                    check_val({nm, ".wait_bubble"}, {VF3, RegWrite3, R_V_dest3}, 0);
                    @(posedge clk); #1;
                end
                mem_if.mem_ack   = 1'b1;
                mem_if.mem_rdata = rl;
                @(negedge clk);
                check_val({nm, ".req"}, mem_if.mem_req, 1);
                check_val({nm, ".we"}, mem_if.mem_we, mw);
                check_val({nm, ".addr"}, mem_if.mem_addr, a);
                if (mw) check_val({nm, ".wdata"}, mem_if.mem_wdata, wl);
                check_val({nm, ".ack_stall"}, stall, (b != nb - 1));
                check_val({nm, ".ack_bubble"}, {VF3, RegWrite3, R_V_dest3}, 0);
                @(posedge clk); #1;
                mem_if.mem_ack = 1'b0;
                exp_res = exp_res | ({96'b0, rl} << (32 * b));
            end
            if (mw) exp_res = res1;
            check_val({nm, ".res"}, ResRV, exp_res);
            check_val({nm, ".rw3"}, RegWrite3, rw && !mw);
            check_val({nm, ".req_after"}, mem_if.mem_req, 0);
        end
        check_val({nm, ".vf3"}, VF3, vf);
        check_val({nm, ".dest3"}, R_V_dest3, dest);
        $display("txn %-10s rd=%0d wr=%0d vf=%0d addr=%h res=%h", nm, mr, mw, vf, alures, exp_res);
    endtask

    initial begin
        int kind;
        int w[4];
        rst = 1'b0;
        MemRead2 = 0; MemWrite2 = 0; RegWrite2 = 0; VF2 = 0;
        R_V_dest2 = '0; ALURES = '0; ALURES1 = '0; R3_V3_2 = '0;
        mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
        #12;
        check_val("reset.res", ResRV, 0);
        check_val("reset.ctl", {VF3, RegWrite3, R_V_dest3, stall, mem_if.mem_req}, 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_op("alu", 0, 0, 1, 0, 4'd5, 32'h0, 128'h1234, '0, '0, '{0, 0, 0, 0}, 0);
        run_op("ld_scalar", 1, 0, 1, 0, 4'd2, 32'h103, rand128(), '0,
               128'hDEADBEEF, '{1, 0, 0, 0}, 0);
        run_op("st_vec", 0, 1, 1, 1, 4'd3, 32'hFFFF_FFF8, rand128(),
               {32'd4, 32'd3, 32'd2, 32'd1}, '0, '{0, 0, 0, 0}, 0);
        run_op("ld_vec", 1, 0, 1, 1, 4'd6, 32'h40, rand128(), '0,
               {32'hD, 32'hC, 32'hB, 32'hA}, '{0, 2, 0, 1}, 0);
        run_op("alu_ack", 0, 0, 1, 1, 4'd7, 32'h0, 128'h5A5A, '0, '0, '{0, 0, 0, 0}, 1);

        // Reset in beat 2 of a vector load
        MemRead2 = 1; MemWrite2 = 0; VF2 = 1; RegWrite2 = 1; R_V_dest2 = 4'd9;
        ALURES = 32'h2000; ALURES1 = rand128(); R3_V3_2 = rand128();
        @(posedge clk); #1;
        mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'h1111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_if.mem_ack = 1'b0;
        @(negedge clk);
        check_val("rst_mid.addr_b2", mem_if.mem_addr, 32'h2008);
        #1 rst = 1'b0;
        #1;
        check_val("rst_mid.req", mem_if.mem_req, 0);
        check_val("rst_mid.stall", stall, 0);
        check_val("rst_mid.res", ResRV, 0);
        check_val("rst_mid.ctl", {VF3, RegWrite3, R_V_dest3, mem_if.mem_we, mem_if.mem_addr}, 0);
        MemRead2 = 0; VF2 = 0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        run_op("alu_post", 0, 0, 1, 0, 4'd11, 32'h0, 128'hCAFE, '0, '0, '{0, 0, 0, 0}, 0);

`ifdef MEM_TIMEOUT_EN
        // Watchdog: no ack ever, abort on the 8th BUSY cycle
        check_val("to.err_before", mem_err, 0);
        MemRead2 = 1; MemWrite2 = 0; VF2 = 0; RegWrite2 = 1; R_V_dest2 = 4'd1;
        ALURES = 32'h80; mem_if.mem_ack = 1'b0;
        @(posedge clk); #1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check_val("to.stall", stall, (c != 8));
            @(posedge clk); #1;
        end
        check_val("to.req", mem_if.mem_req, 0);
        check_val("to.err", mem_err, 1);
        check_val("to.rw3", RegWrite3, 0);
        run_op("alu_to", 0, 0, 1, 0, 4'd4, 32'h0, 128'h77, '0, '0, '{0, 0, 0, 0}, 0);
        check_val("to.err_sticky", mem_err, 1);
`endif

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            for (int b = 0; b < 4; b++) w[b] = $urandom_range(0, 3);
            run_op($sformatf("rnd%0d", i), kind == 1 || kind == 3, kind >= 2,
                   1'($urandom), 1'($urandom), 4'($urandom), $urandom,
                   rand128(), rand128(), rand128(), w, 1'($urandom));
        end

        MemRead2 = 0; MemWrite2 = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/memory_stage_unit.md
Name: memory_stage_unit

Overview:
- Pipeline stage directly downstream of the execute stage. Consumes the scalar result/address, the 128-bit vector result, the store data and the vector flag.
- Performs scalar (1-beat) or vector (4-beat) loads/stores over a 32-bit req/ack data-memory bus. Stalls upstream while an access is in flight.
- Registers the stage-3 result (VF3, R_V_dest3, ResRV) that feeds writeback and the execute-stage forwarding unit.

Parameters:
- ADDR_W, 32, address width and scalar ALU result width.
- VEC_W, 128, vector result/store data width.
- BUS_W, 32, memory data bus width; VEC_W/BUS_W = 4 beats.
- REG_W, 4, register/vector destination index width.
- TIMEOUT_CYC, 255, ack watchdog limit. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all flops on rising edge.
- rst  in  1  asynchronous, active-low reset.
- MemRead2  in  1  load request.
- MemWrite2  in  1  store request.
- RegWrite2  in  1  instruction writes a register.
- VF2  in  1  vector instruction flag.
- R_V_dest2  in  REG_W  destination register index.
- ALURES  in  ADDR_W  scalar result / memory address.
- ALURES1  in  VEC_W  ALU result, scalar zero-extended or vector.
- R3_V3_2  in  VEC_W  store data.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  BUS_W  write data.
- mem_rdata  in  BUS_W  read data, valid with mem_ack.
- mem_ack  in  1  beat complete.
- stall  out  1  upstream must hold its inputs.
- VF3  out  1  registered vector flag.
- RegWrite3  out  1  registered write enable.
- R_V_dest3  out  REG_W  registered destination index.
- ResRV  out  VEC_W  registered result.

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE, beat counter 0, all outputs 0, mem_req drops immediately. Reset mid-access abandons the access; nothing is written back.
- Non-memory instruction (MemRead2=MemWrite2=0):
  - 1-cycle latency, stall=0.
  - Next edge: ResRV<=ALURES1, VF3<=VF2, R_V_dest3<=R_V_dest2, RegWrite3<=RegWrite2.
- Memory instruction arriving in IDLE:
  - stall=1 combinationally in the same cycle. FSM moves to BUSY at the next edge.
  - MemWrite2 has priority if both request bits are set.
  - Beats: N=4 if VF2 else 1.
- BUSY:
  - mem_req=1.
  - mem_addr = {ALURES[31:2],2'b00} + 4*beat, modulo 2^32 (wraps).
  - mem_we = store flag.
  - mem_wdata = R3_V3_2[32*beat+31 : 32*beat].
  - Address, we and wdata stay stable until mem_ack. A beat completes on a cycle with mem_req&&mem_ack.
  - Load data: rdata goes to lane beat, bits [32*beat+31:32*beat] of an internal buffer. A scalar load zero-extends to 128 bits.
  - Non-final ack: beat++. The next beat is presented in the following cycle with req kept high.
  - Final ack: stall=0 in that same cycle (combinational on ack), so upstream advances at that edge. At that edge FSM goes to IDLE and the output registers load:
    - ResRV = assembled load data; a store leaves ResRV = ALURES1.
    - RegWrite3 = RegWrite2 & ~store.
  - mem_ack while in IDLE is ignored.
- While BUSY and not on the final ack, outputs are a bubble: RegWrite3=0, VF3=0, R_V_dest3=0. ResRV holds its value.
- Upstream inputs are sampled only at the last edge of the access and must be stable throughout.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - Adds output port mem_err (1 bit) and a wait counter that resets on every ack.
  - If TIMEOUT_CYC cycles pass in BUSY without ack, the access aborts: FSM to IDLE, stall=0, bubble written (RegWrite3=0).
  - mem_err is set sticky and cleared only by reset.
- Undefined: no port, no counter; BUSY waits for ack indefinitely.

Decomposition:
- Package mem_stage_pkg:
  - typedef enum ms_state_t {MS_IDLE, MS_BUSY}
  - localparams BEATS_VEC=4, BEAT_BYTES=4, BEAT_CNT_W=2
- Sub-module mem_beat_ctrl holds the FSM, beat counter, address generation and timeout counter; it outputs beat, last_beat and stall.
- The top level does lane select/assembly and the output registers.

Test Plan:
- ALU op, VF2=0, ALURES1=0x1234, RegWrite2=1, R_V_dest2=5 -> next cycle ResRV=0x1234, RegWrite3=1, R_V_dest3=5, stall never 1.
- Scalar load at ALURES=0x103, ack on 2nd BUSY cycle, rdata=0xDEADBEEF -> mem_addr=0x100, stall high 2 cycles, then ResRV=0x...0DEADBEEF, RegWrite3=1.
- Vector store at 0xFFFFFFF8, R3_V3_2 = lanes {4,3,2,1}, immediate acks -> addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004 with wdata 1,2,3,4; RegWrite3=0.
- Vector load with rdata 0xA,0xB,0xC,0xD and 0/2/0/1 wait cycles -> ResRV={D,C,B,A}; bubbles with RegWrite3=0 throughout the access.
- rst low during beat 2 of a vector load -> mem_req=0 and all outputs 0 without a clock edge; after release the next ALU op completes normally.
- With MEM_TIMEOUT_EN, TIMEOUT_CYC=8, ack never asserted -> abort after 8 cycles, mem_err=1 sticky, stall=0, RegWrite3=0.
